// File: rtl/fsk_demodulate_if.sv
// Signal bundle between the FSK line receiver and the downstream Hamming decoder.
// The master side is the demodulator: it samples fsk and drives the decoded results.
interface fsk_demodulate_if #(
    parameter int N_BITS = 14
);
    // code_valid is a one-cycle strobe with no ready; the consumer must capture
    // code/frame_err in that cycle. Likewise bit_strobe qualifies bit_val/symbol_err.
    logic              fsk;
    logic [N_BITS-1:0] code;
    logic              code_valid;
    logic              frame_err;
    logic              bit_strobe;
    logic              bit_val;
    logic              symbol_err;
    logic [3:0]        bit_idx;

    modport master (
        input  fsk,
        output code, code_valid, frame_err, bit_strobe, bit_val, symbol_err, bit_idx
    );

    modport slave (
        output fsk,
        input  code, code_valid, frame_err, bit_strobe, bit_val, symbol_err, bit_idx
    );
endinterface

// File: rtl/fsk_demodulate.sv
// FSK demodulator: counts line transitions in fixed bit windows, decides 1/0 per
// window and reassembles LSB-first codewords for the Hamming decoder.
module fsk_demodulate #(
    parameter int BIT_CYCLES = 16,
    parameter int N_BITS     = 14,
    parameter int THRESH     = 12,
    parameter int SKEW       = 2
) (
    input  logic                clk2,
    input  logic                reset,
    fsk_demodulate_if.master    bus,
    output logic                state_o
);

    localparam int WW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int SW = (SKEW > 1) ? $clog2(SKEW) : 1;
    localparam logic [WW-1:0] WLAST     = WW'(BIT_CYCLES - 1);
    localparam logic [SW-1:0] SKEW_LAST = SW'(SKEW - 1);
    localparam logic [3:0]    IDX_LAST  = 4'(N_BITS - 1);
    localparam logic [4:0]    THR       = 5'(THRESH);

    typedef enum logic {
        ST_STARTUP = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                fsk_q, fsk_q2;
    logic [SW-1:0]       skew_q, skew_d;
    logic [WW-1:0]       wcnt_q, wcnt_d;
    logic [4:0]          ecnt_q, ecnt_d;
    logic [N_BITS-2:0]   shreg_q, shreg_d;
    logic [3:0]          idx_q, idx_d;
    logic                sticky_q, sticky_d;
    logic [N_BITS-1:0]   code_q, code_d;
    logic                code_valid_q, code_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                bit_strobe_q, bit_strobe_d;
    logic                bit_val_q, bit_val_d;
    logic                symbol_err_q, symbol_err_d;

    logic                tr;
    logic [5:0]          sum;
    logic [4:0]          total;
    logic                dec_bit;
    logic                dec_err;

    assign tr = fsk_q ^ fsk_q2;

    always_comb begin
        state_d      = state_q;
        skew_d       = skew_q;
        wcnt_d       = wcnt_q;
        ecnt_d       = ecnt_q;
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        sticky_d     = sticky_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        frame_err_d  = frame_err_q;
        bit_strobe_d = 1'b0;
        bit_val_d    = bit_val_q;
        symbol_err_d = symbol_err_q;

        // Saturating count including the transition seen on this edge.
        sum     = {1'b0, ecnt_q} + {5'd0, tr};
        total   = sum[5] ? 5'd31 : sum[4:0];
        dec_bit = (total >= THR);
        // Totals between the nominal 8 and 16 that sit near the threshold are suspect.
        dec_err = (total < 5'd4) || ((total > 5'd10) && (total < 5'd14));

        case (state_q)
            ST_STARTUP: begin
                if (skew_q == SKEW_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    skew_d = skew_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (wcnt_q == WLAST) begin
                    wcnt_d       = '0;
                    ecnt_d       = '0;
                    bit_strobe_d = 1'b1;
                    bit_val_d    = dec_bit;
                    symbol_err_d = dec_err;
                    if (idx_q == IDX_LAST) begin
                        idx_d        = '0;
                        code_d       = {dec_bit, shreg_q};
                        frame_err_d  = sticky_q | dec_err;
                        code_valid_d = 1'b1;
                        sticky_d     = 1'b0;
                    end else begin
                        shreg_d[idx_q] = dec_bit;
                        idx_d          = idx_q + 1'b1;
                        sticky_d       = sticky_q | dec_err;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                    ecnt_d = total;
                end
            end
            default: state_d = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_STARTUP;
            fsk_q        <= 1'b0;
            fsk_q2       <= 1'b0;
            skew_q       <= '0;
            wcnt_q       <= '0;
            ecnt_q       <= '0;
            shreg_q      <= '0;
            idx_q        <= '0;
            sticky_q     <= 1'b0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            bit_strobe_q <= 1'b0;
            bit_val_q    <= 1'b0;
            symbol_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fsk_q        <= bus.fsk;
            fsk_q2       <= fsk_q;
            skew_q       <= skew_d;
            wcnt_q       <= wcnt_d;
            ecnt_q       <= ecnt_d;
            shreg_q      <= shreg_d;
            idx_q        <= idx_d;
            sticky_q     <= sticky_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            bit_strobe_q <= bit_strobe_d;
            bit_val_q    <= bit_val_d;
            symbol_err_q <= symbol_err_d;
        end
    end

    assign bus.code       = code_q;
    assign bus.code_valid = code_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.bit_strobe = bit_strobe_q;
    assign bus.bit_val    = bit_val_q;
    assign bus.symbol_err = symbol_err_q;
    assign bus.bit_idx    = idx_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_fsk_demodulate.sv
// Bench for fsk_demodulate: a behavioural FSK modulator feeds the line and every
// cycle is compared against hand-derived window/frame timing and codewords.
module tb_fsk_demodulate;

  typedef struct {
    logic [13:0] word;
    int          delay;
    int          frames;
    bit          idle;
    int          err_win;
    int          err_cnt;
    bit          err_bit;
    bit          err_sym;
    logic [13:0] code0;
    bit          ferr0;
    logic [13:0] code_n;
    bit          ferr_n;
  } vec_t;

  logic clk2;
  logic reset;
  logic state_dbg;
  int   checks;
  int   errors;
  vec_t vecs[11];

  fsk_demodulate_if bus ();

  fsk_demodulate dut (
    .clk2    (clk2),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // clock / reset
  initial begin
    clk2 = 1'b0;
    forever #5 clk2 = ~clk2;
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%h required=%h", nm, d, act, exp);
    end
  endtask

  task automatic check_reset();
    chk("rst_code", 0, 32'(bus.code), 0);
    chk("rst_code_valid", 0, 32'(bus.code_valid), 0);
    chk("rst_frame_err", 0, 32'(bus.frame_err), 0);
    chk("rst_bit_strobe", 0, 32'(bus.bit_strobe), 0);
    chk("rst_bit_val", 0, 32'(bus.bit_val), 0);
    chk("rst_symbol_err", 0, 32'(bus.symbol_err), 0);
    chk("rst_bit_idx", 0, 32'(bus.bit_idx), 0);
    chk("rst_state", 0, 32'(state_dbg), 0);
  endtask

  // Modulator model: toggle decision after modulator edge s (s from 1).
  function automatic bit tog(input vec_t v, input int s);
    int win;
    int off;
    win = (s - 1) / 16;
    off = (s - 1) % 16;
    if (v.idle) return 1'b0;
    if (v.err_win >= 0 && win == v.err_win) return (off < v.err_cnt);
    if (v.word[win % 14]) return 1'b1;
    return (off % 2) == 0;
  endfunction

  function automatic vec_t mk(input logic [13:0] word, input int delay, input int frames,
                              input bit idle, input int err_win, input int err_cnt,
                              input bit err_bit, input bit err_sym,
                              input logic [13:0] code0, input bit ferr0,
                              input logic [13:0] code_n, input bit ferr_n);
    vec_t v;
    v.word = word; v.delay = delay; v.frames = frames; v.idle = idle;
    v.err_win = err_win; v.err_cnt = err_cnt; v.err_bit = err_bit; v.err_sym = err_sym;
    v.code0 = code0; v.ferr0 = ferr0; v.code_n = code_n; v.ferr_n = ferr_n;
    return v;
  endfunction

  // driver + per-cycle scoreboard; abort_at > 0 asserts reset after that demod edge
  task automatic run_case(input vec_t v, input int abort_at);
    int ncyc;
    int d;
    int k;
    int m;
    bit se;
    bit ve;
    bit eb;
    bit es;
    logic [13:0] held;
    reset   = 1'b1;
    bus.fsk = 1'b0;
    repeat (3) @(posedge clk2);
    #1;
    check_reset();
    held = 14'h0;
    if (v.delay == 0) reset = 1'b0;
    ncyc = v.delay + 2 + 224 * v.frames + 20;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk2);
      #1;
      d = i - v.delay;
      if (d >= 1) begin
        chk("state", d, 32'(state_dbg), (d >= 2) ? 1 : 0);
        se = (d >= 18) && ((d - 2) % 16 == 0);
        chk("bit_strobe", d, 32'(bus.bit_strobe), 32'(se));
        chk("bit_idx", d, 32'(bus.bit_idx), (d >= 18) ? ((d - 2) / 16) % 14 : 0);
        if (se) begin
          k = (d - 2) / 16 - 1;
          if (v.idle) begin
            eb = 1'b0; es = 1'b1;
          end else if (v.err_win >= 0 && k == v.err_win) begin
            eb = v.err_bit; es = v.err_sym;
          end else begin
            eb = v.word[k % 14]; es = 1'b0;
          end
          chk("bit_val", d, 32'(bus.bit_val), 32'(eb));
          chk("symbol_err", d, 32'(bus.symbol_err), 32'(es));
        end
        ve = (d >= 226) && ((d - 2) % 224 == 0);
        chk("code_valid", d, 32'(bus.code_valid), 32'(ve));
        if (ve) begin
          m = (d - 2) / 224 - 1;
          held = (m == 0) ? v.code0 : v.code_n;
          chk("frame_err", d, 32'(bus.frame_err), (m == 0) ? 32'(v.ferr0) : 32'(v.ferr_n));
        end
        chk("code", d, 32'(bus.code), 32'(held));
        if (d == abort_at) begin
          reset = 1'b1;
          #1;
          check_reset();
          return;
        end
      end
      if (i == v.delay) reset = 1'b0;
      bus.fsk = bus.fsk ^ tog(v, i);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    bus.fsk = 1'b0;

    //              word      dly frm idle win cnt eb es  code0     f0  code_n    fn
    vecs[0]  = mk(14'h1A5C, 0, 3, 0, -1,  0, 0, 0, 14'h1A5C, 0, 14'h1A5C, 0);
    vecs[1]  = mk(14'h3FFF, 0, 1, 0, -1,  0, 0, 0, 14'h3FFF, 0, 14'h3FFF, 0);
    vecs[2]  = mk(14'h0000, 0, 1, 0, -1,  0, 0, 0, 14'h0000, 0, 14'h0000, 0);
    vecs[3]  = mk(14'h0000, 0, 2, 1, -1,  0, 0, 0, 14'h0000, 1, 14'h0000, 1);
    vecs[4]  = mk(14'h2B37, 1, 2, 0, -1,  0, 0, 0, 14'h2B37, 0, 14'h2B37, 0);
    vecs[5]  = mk(14'h2B37, 0, 2, 0,  3, 12, 1, 1, 14'h2B3F, 1, 14'h2B37, 0);
    vecs[6]  = mk(14'h2B37, 0, 1, 0,  3, 10, 0, 0, 14'h2B37, 0, 14'h2B37, 0);
    vecs[7]  = mk(14'h2B37, 0, 1, 0,  3, 14, 1, 0, 14'h2B3F, 0, 14'h2B37, 0);
    vecs[8]  = mk(14'h2B37, 0, 1, 0,  3,  3, 0, 1, 14'h2B37, 1, 14'h2B37, 0);
    vecs[9]  = mk(14'h2B37, 0, 1, 0,  3, 11, 0, 1, 14'h2B37, 1, 14'h2B37, 0);
    vecs[10] = mk(14'h2B37, 0, 1, 0,  3, 13, 1, 1, 14'h2B3F, 1, 14'h2B37, 0);

    for (int n = 0; n < 11; n++) begin
      run_case(vecs[n], 0);
    end

    // Reset mid-frame: during bit 7 of the first frame, then during bit 7 of the
    // second frame (code already holding 1A5C), then a clean restart.
    run_case(vecs[0], 120);
    run_case(vecs[0], 344);
    run_case(vecs[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
